master_controller: RTL and testbench
====================================

MASTER_CONTROLLER -- requirements
Module: master_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum RUN-state cycles before a forced drop.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pkt_avail  input  1  input FIFO holds a complete packet.
REQ-005 pipe_start  output  1  one-cycle pulse that launches pipeline processing of the packet.
REQ-006 master_vld  input  1  a Master_Control instruction (opcode 30) retired this cycle.
REQ-007 master_reg  input  3  routing code from decode: 0 no match, 1 source 0, 2 source 1, 3..6 dest 0..3.
REQ-008 pl_done  input  1  pulse: pipeline executed its last instruction (opcode 25, func3 1).
REQ-009 route_valid  output  1  routing decision valid.
REQ-010 route_code  output  3  latched routing code; 0 means drop.
REQ-011 route_ready  input  1  output stage accepts the decision.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 pkt_count  output  16  packets routed or dropped since reset.
REQ-014 err_invalid  output  1  sticky flag: code 7 received.
REQ-015 err_timeout  output  1  sticky flag: watchdog expired.

Function
REQ-016 FSM states SHALL be IDLE, START, RUN and ROUTE; all outputs SHALL be registered (Moore).
REQ-017 IDLE: pkt_avail=1 -> START on the next edge; otherwise stay.
REQ-018 START: pipe_start=1 for exactly that cycle; latched code cleared to 0; watchdog cleared; -> RUN.
REQ-019 RUN: master_vld=1 latches master_reg; the last write wins; code 7 latches 0 and sets err_invalid.
REQ-020 RUN: pl_done=1 -> ROUTE; route_valid SHALL assert on the cycle after the pl_done cycle (latency 1).
REQ-021 master_vld and pl_done in the same cycle: that master_reg SHALL be latched and used for the route.
REQ-022 RUN: watchdog increments each cycle; at count TIMEOUT_CYCLES-1 with no pl_done -> ROUTE with code 0, err_timeout set.
REQ-023 pl_done and watchdog expiry in the same cycle: pl_done wins; no timeout flag is set.
REQ-024 ROUTE: route_valid=1 with route_code held stable until route_ready=1; stall is unbounded.
REQ-025 ROUTE handshake (route_valid & route_ready): pkt_count increments, wrapping 0xFFFF->0x0000; -> IDLE; route_valid deasserts on the next cycle.
REQ-026 master_vld and pl_done outside RUN SHALL be ignored; pkt_avail is sampled only in IDLE.
REQ-027 Back-to-back packets: pkt_avail held high SHALL produce START two cycles after the handshake (ROUTE->IDLE->START).
REQ-028 err_invalid and err_timeout SHALL clear only on reset.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and drive pipe_start, route_valid, busy, err_invalid and err_timeout to 0, route_code to 0, pkt_count to 0, and the watchdog to 0.
REQ-030 Reset mid-packet (any state) SHALL abandon the packet with no route and no count.
REQ-031 The first state transition after rst_n rises SHALL occur on the first rising clk edge.

Structure
REQ-032 A shared package SHALL hold the state encoding, the routing-code constants (MC_NOMATCH=0, MC_SRC0=1, MC_SRC1=2, MC_DST0..MC_DST3=3..6, MC_INVALID=7), and the TIMEOUT_CYCLES default.
REQ-033 The watchdog SHALL be one sub-module, mc_watchdog (clear, enable, expire outputs), sized ceil(log2(TIMEOUT_CYCLES)) bits.

Verification
REQ-034 Normal flow: pkt_avail=1 -> pipe_start pulse; master_vld with code 4; pl_done -> route_valid, route_code=4 next cycle; route_ready=1 -> pkt_count=1, IDLE.
REQ-035 Multiple codes: master_vld with 1, then 5, then 3 in RUN, then pl_done -> route_code=3.
REQ-036 Simultaneous events: master_vld code 6 with pl_done in the same cycle -> route_code=6; separately, code 7 -> route_code=0 and err_invalid=1.
REQ-037 Timeout (TIMEOUT_CYCLES=16): no pl_done -> ROUTE after 16 RUN cycles, route_code=0, err_timeout=1; pl_done on the expiry cycle -> err_timeout stays 0.
REQ-038 Backpressure and wrap: route_ready low for 10 cycles -> route_code stable, no count; preload pkt_count to 0xFFFF -> handshake gives 0x0000.
REQ-039 Reset in RUN and in ROUTE: all outputs reach reset values immediately; a later packet routes normally.

Source files
------------

// File: rtl/master_controller_pkg.sv
// Shared definitions for the packet master controller: FSM state encoding,
// routing-code constants and the default watchdog limit.
// Imported by master_controller and mc_watchdog.
package master_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_ROUTE = 2'd3
  } mc_state_t;

  localparam logic [2:0] MC_NOMATCH = 3'd0;
  localparam logic [2:0] MC_SRC0    = 3'd1;
  localparam logic [2:0] MC_SRC1    = 3'd2;
  localparam logic [2:0] MC_DST0    = 3'd3;
  localparam logic [2:0] MC_DST1    = 3'd4;
  localparam logic [2:0] MC_DST2    = 3'd5;
  localparam logic [2:0] MC_DST3    = 3'd6;
  localparam logic [2:0] MC_INVALID = 3'd7;

  localparam int MC_TIMEOUT_DEFAULT = 1024;

  // An invalid code is stored as "drop" so it can never steer a packet.
  function automatic logic [2:0] mc_filter_code(input logic [2:0] code);
    return (code == MC_INVALID) ? MC_NOMATCH : code;
  endfunction

endpackage

// File: rtl/mc_watchdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the last allowed one.
// Latency: expire is combinational from the count (high on count TIMEOUT_CYCLES-1 while enabled).
// Backpressure: none; clear has priority over enable, count saturates at the limit.
// Ports: clk, rst_n (async active-low), clear, enable in; expire out.
module mc_watchdog
  import master_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MC_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/master_controller.sv
// Packet master controller: launches the pipeline, collects the routing code
// from Master_Control instructions and hands a route decision to the output stage.
// Latency: START one cycle after pkt_avail in IDLE; route_valid one cycle after pl_done.
// Backpressure: route_valid/route_code held indefinitely until route_ready.
// Ports: clk, rst_n, pkt_avail, master_vld, master_reg, pl_done, route_ready in;
//        pipe_start, route_valid, route_code, busy, pkt_count, err_invalid, err_timeout out.
module master_controller
  import master_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MC_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_avail,
  output logic        pipe_start,
  input  logic        master_vld,
  input  logic [2:0]  master_reg,
  input  logic        pl_done,
  output logic        route_valid,
  output logic [2:0]  route_code,
  input  logic        route_ready,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic        err_invalid,
  output logic        err_timeout
);

  mc_state_t  state;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expire;
  logic [2:0] run_code;

  assign wd_clear  = (state == ST_START);
  assign wd_enable = (state == ST_RUN);

  mc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Code as it stands after this cycle's retire; lets a master_vld that
  // coincides with pl_done still decide the route.
  always_comb begin
    run_code = route_code;
    if (master_vld) begin
      run_code = mc_filter_code(master_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pipe_start  <= 1'b0;
      route_valid <= 1'b0;
      route_code  <= MC_NOMATCH;
      busy        <= 1'b0;
      pkt_count   <= 16'd0;
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pkt_avail) begin
            state      <= ST_START;
            pipe_start <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ST_START: begin
          state      <= ST_RUN;
          pipe_start <= 1'b0;
          route_code <= MC_NOMATCH;
        end

        ST_RUN: begin
          if (master_vld && (master_reg == MC_INVALID)) begin
            err_invalid <= 1'b1;
          end
          // pl_done outranks a coincident watchdog expiry.
          if (pl_done) begin
            state       <= ST_ROUTE;
            route_valid <= 1'b1;
            route_code  <= run_code;
          end else if (wd_expire) begin
            state       <= ST_ROUTE;
            route_valid <= 1'b1;
            route_code  <= MC_NOMATCH;
            err_timeout <= 1'b1;
          end else begin
            route_code  <= run_code;
          end
        end

        ST_ROUTE: begin
          if (route_ready) begin
            state       <= ST_IDLE;
            route_valid <= 1'b0;
            busy        <= 1'b0;
            pkt_count   <= pkt_count + 16'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_controller.sv
// Randomized bench for master_controller with a packet-level expectation model.
module tb_master_controller;
  import master_controller_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_avail = 1'b0;
  logic        master_vld = 1'b0;
  logic [2:0]  master_reg = 3'd0;
  logic        pl_done = 1'b0;
  logic        route_ready = 1'b0;
  logic        pipe_start;
  logic        route_valid;
  logic [2:0]  route_code;
  logic        busy;
  logic [15:0] pkt_count;
  logic        err_invalid;
  logic        err_timeout;

  master_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkt_avail   (pkt_avail),
    .pipe_start  (pipe_start),
    .master_vld  (master_vld),
    .master_reg  (master_reg),
    .pl_done     (pl_done),
    .route_valid (route_valid),
    .route_code  (route_code),
    .route_ready (route_ready),
    .busy        (busy),
    .pkt_count   (pkt_count),
    .err_invalid (err_invalid),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ps;
    logic        rv;
    logic        bz;
    logic        einv;
    logic        eto;
    logic [2:0]  code;
    logic [15:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;

  // Packet-level model state: what the spec says the sticky/latched outputs hold.
  logic [15:0] m_cnt = 16'd0;
  logic [2:0]  m_code = 3'd0;
  logic        m_einv = 1'b0;
  logic        m_eto = 1'b0;

  // Compare process: entry pushed for an edge is checked at the following negedge.
  exp_t ce;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      total++;
      if ({pipe_start, route_valid, busy, err_invalid, err_timeout, pkt_count} !==
          {ce.ps, ce.rv, ce.bz, ce.einv, ce.eto, ce.cnt}) begin
        bad++;
        $display("FAIL outputs t=%0t got ps=%b rv=%b busy=%b einv=%b eto=%b cnt=%h exp ps=%b rv=%b busy=%b einv=%b eto=%b cnt=%h",
                 $time, pipe_start, route_valid, busy, err_invalid, err_timeout, pkt_count,
                 ce.ps, ce.rv, ce.bz, ce.einv, ce.eto, ce.cnt);
      end
      if (ce.rv) begin
        total++;
        if (route_code !== ce.code) begin
          bad++;
          $display("FAIL route_code t=%0t got %0d exp %0d", $time, route_code, ce.code);
        end
      end
    end
  end

  function automatic logic nz();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] nzr();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one edge's inputs (called at negedge+1) and record what must follow it.
  task automatic cyc(input logic a, input logic mv, input logic [2:0] mr, input logic pd,
                     input logic rr, input logic e_ps, input logic e_rv, input logic e_bz);
    exp_t e;
    pkt_avail   = a;
    master_vld  = mv;
    master_reg  = mr;
    pl_done     = pd;
    route_ready = rr;
    e.ps = e_ps; e.rv = e_rv; e.bz = e_bz;
    e.einv = m_einv; e.eto = m_eto; e.code = m_code; e.cnt = m_cnt;
    expq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // IDLE edge with pkt_avail, then the START edge; unrelated inputs carry noise.
  task automatic start_pkt();
    cyc(1'b1, nz(), nzr(), nz(), nz(), 1'b1, 1'b0, 1'b1);
    m_code = MC_NOMATCH;
    cyc(nz(), nz(), nzr(), nz(), nz(), 1'b0, 1'b0, 1'b1);
  endtask

  // One RUN edge; i is the number of RUN cycles already spent on this packet.
  task automatic run_edge(input logic mv, input logic [2:0] mr, input logic pd, input int i);
    logic done;
    if (mv) begin
      if (mr == 3'd7) begin
        m_code = 3'd0;
        m_einv = 1'b1;
      end else begin
        m_code = mr;
      end
    end
    done = pd || (i == T - 1);
    if (!pd && (i == T - 1)) begin
      m_code = 3'd0;
      m_eto  = 1'b1;
    end
    cyc(nz(), mv, mr, pd, nz(), 1'b0, done, 1'b1);
  endtask

  task automatic hold(input int n);
    for (int s = 0; s < n; s++) cyc(nz(), nz(), nzr(), nz(), 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic route(input int stall, input logic next_avail);
    hold(stall);
    m_cnt = m_cnt + 16'd1;
    cyc(next_avail, nz(), nzr(), nz(), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < n; g++) cyc(1'b0, nz(), nzr(), nz(), nz(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    lit({tag, "_pipe_start"},  {15'd0, pipe_start},  16'd0);
    lit({tag, "_route_valid"}, {15'd0, route_valid}, 16'd0);
    lit({tag, "_busy"},        {15'd0, busy},        16'd0);
    lit({tag, "_route_code"},  {13'd0, route_code},  16'd0);
    lit({tag, "_pkt_count"},   pkt_count,            16'd0);
    lit({tag, "_err_invalid"}, {15'd0, err_invalid}, 16'd0);
    lit({tag, "_err_timeout"}, {15'd0, err_timeout}, 16'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    pkt_avail = 1'b0; master_vld = 1'b0; pl_done = 1'b0; route_ready = 1'b0;
    #1;
    check_reset_outputs(tag);
    m_cnt = 16'd0; m_code = 3'd0; m_einv = 1'b0; m_eto = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int       n_run;
  int       stall;
  int       gap;
  logic     pd_end;
  logic     mv;
  logic     pd;
  logic [2:0] mr;

  initial begin
    @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Normal flow with code 4.
    start_pkt();
    run_edge(1'b1, 3'd4, 1'b0, 0);
    run_edge(1'b0, 3'd0, 1'b1, 1);
    lit("normal_code", {13'd0, route_code}, 16'd4);
    route(0, 1'b0);
    lit("normal_count", pkt_count, 16'd1);
    lit("normal_busy", {15'd0, busy}, 16'd0);
    idle(1);

    // Last write wins.
    start_pkt();
    run_edge(1'b1, 3'd1, 1'b0, 0);
    run_edge(1'b1, 3'd5, 1'b0, 1);
    run_edge(1'b1, 3'd3, 1'b0, 2);
    run_edge(1'b0, 3'd0, 1'b1, 3);
    lit("multi_code", {13'd0, route_code}, 16'd3);
    route(2, 1'b1);

    // master_vld together with pl_done (back-to-back start).
    start_pkt();
    run_edge(1'b0, 3'd0, 1'b0, 0);
    run_edge(1'b1, 3'd6, 1'b1, 1);
    lit("simul_code", {13'd0, route_code}, 16'd6);
    route(0, 1'b0);

    // pl_done on the expiry cycle: no timeout.
    start_pkt();
    for (int i = 0; i < T - 1; i++) run_edge(1'b0, 3'd0, 1'b0, i);
    run_edge(1'b1, 3'd2, 1'b1, T - 1);
    lit("pd_expiry_eto", {15'd0, err_timeout}, 16'd0);
    lit("pd_expiry_code", {13'd0, route_code}, 16'd2);
    route(0, 1'b0);

    // Invalid code.
    start_pkt();
    run_edge(1'b1, 3'd7, 1'b0, 0);
    run_edge(1'b0, 3'd0, 1'b1, 1);
    lit("invalid_code", {13'd0, route_code}, 16'd0);
    lit("invalid_flag", {15'd0, err_invalid}, 16'd1);
    route(0, 1'b0);

    // Full timeout after T RUN cycles.
    start_pkt();
    for (int i = 0; i < T; i++) run_edge(1'b0, 3'd0, 1'b0, i);
    lit("timeout_code", {13'd0, route_code}, 16'd0);
    lit("timeout_flag", {15'd0, err_timeout}, 16'd1);
    route(0, 1'b0);

    // Long backpressure, then counter wrap.
    start_pkt();
    run_edge(1'b1, 3'd2, 1'b1, 0);
    hold(10);
    lit("stall_code", {13'd0, route_code}, 16'd2);
    lit("stall_count", pkt_count, 16'd6);
    route(0, 1'b0);
    force dut.pkt_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    idle(1);
    release dut.pkt_count;
    idle(1);
    lit("preload", pkt_count, 16'hFFFF);
    start_pkt();
    run_edge(1'b0, 3'd0, 1'b1, 0);
    route(1, 1'b0);
    lit("wrap", pkt_count, 16'h0000);

    // Reset in RUN, then reset in ROUTE, then a normal packet.
    start_pkt();
    run_edge(1'b1, 3'd5, 1'b0, 0);
    do_reset("rst_run");
    start_pkt();
    run_edge(1'b1, 3'd7, 1'b1, 0);
    hold(2);
    do_reset("rst_route");
    start_pkt();
    run_edge(1'b1, 3'd3, 1'b1, 0);
    lit("post_reset_code", {13'd0, route_code}, 16'd3);
    route(0, 1'b0);
    lit("post_reset_count", pkt_count, 16'd1);

    // Randomized packets.
    for (int p = 0; p < 80; p++) begin
      n_run  = $urandom_range(1, T);
      pd_end = nz();
      stall  = $urandom_range(0, 4);
      gap    = $urandom_range(0, 2);
      start_pkt();
      for (int i = 0; i < n_run; i++) begin
        mv = ($urandom_range(0, 2) == 0);
        mr = nzr();
        pd = (i == n_run - 1) && ((n_run < T) || pd_end);
        run_edge(mv, mr, pd, i);
      end
      route(stall, gap == 0);
      if (gap > 1) idle(gap - 1);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
